// File: rtl/game_pkg.sv
// game_pkg: shared encodings and constants for the game datapath blocks.
package game_pkg;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int TIMEOUT_DEFAULT = 50_000_000;
    function automatic logic [1:0] not_count(input logic [1:0] b);
        return (b == 2'd3) ? 2'd0 : b;
    endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifts left one step per i_step.
module lfsr8 import game_pkg::*; #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_step,
    output logic [7:0] o_state
);
    logic [7:0] r_state;
    logic [7:0] w_next;
    assign w_next  = {r_state[6:0], ^(r_state & LFSR_TAPS)};
    assign o_state = r_state;
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= SEED;
        else if (i_step)
            r_state <= w_next;
    end
endmodule

// File: rtl/game_timer_datapath.sv
// game_timer_datapath: transition timer, instruction generator, lives and score
// counters driven by edges of the game FSM control levels.
module game_timer_datapath import game_pkg::*; #(
    parameter int          TIMEOUT   = TIMEOUT_DEFAULT,
    parameter int          CNT_W     = 26,
    parameter int          LIVES     = 3,
    parameter int          LIFE_W    = 2,
    parameter int          SCORE_W   = 8,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable_counter,
    input  logic               i_change_instruction,
    input  logic               i_decrease_life,
    output logic               o_wait_counter,
    output logic [1:0]         o_instr_dir,
    output logic [1:0]         o_instr_not,
    output logic [LIFE_W-1:0]  o_lives,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_game_over
);
    logic               r_ec_q, r_ci_q, r_dl_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wait;
    logic [LIFE_W-1:0]  r_lives;
    logic [SCORE_W-1:0] r_score;
    logic               r_game_over;
    logic               w_ec_rise, w_ci_rise, w_dl_rise;
    logic [LIFE_W-1:0]  w_lives_nxt;
    logic [7:0]         w_lfsr;

    // FSM holds its outputs for several cycles, so only rising edges act
    assign w_ec_rise   = i_enable_counter & ~r_ec_q;
    assign w_ci_rise   = i_change_instruction & ~r_ci_q;
    assign w_dl_rise   = i_decrease_life & ~r_dl_q;
    assign w_lives_nxt = (w_dl_rise && r_lives != '0) ? r_lives - 1'b1 : r_lives;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_ci_rise),
        .o_state (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ec_q      <= 1'b0;
            r_ci_q      <= 1'b0;
            r_dl_q      <= 1'b0;
            r_cnt       <= '0;
            r_wait      <= 1'b1;
            r_lives     <= LIFE_W'(LIVES);
            r_score     <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_ec_q      <= i_enable_counter;
            r_ci_q      <= i_change_instruction;
            r_dl_q      <= i_decrease_life;
            r_lives     <= w_lives_nxt;
            r_game_over <= (w_lives_nxt == '0);
            if (i_enable_counter) begin
                r_cnt  <= '0;
                r_wait <= 1'b0;
            end else if (!r_wait) begin
                if (r_cnt == CNT_W'(TIMEOUT - 1))
                    r_wait <= 1'b1;
                else
                    r_cnt <= r_cnt + 1'b1;
            end
            if (w_ec_rise && !i_decrease_life && r_score != '1)
                r_score <= r_score + 1'b1;
        end
    end

    assign o_wait_counter = r_wait;
    assign o_instr_dir    = dir_e'(w_lfsr[1:0]);
    assign o_instr_not    = not_count(w_lfsr[3:2]);
    assign o_lives        = r_lives;
    assign o_score        = r_score;
    assign o_game_over    = r_game_over;
endmodule

// File: tb/tb_game_timer_datapath.sv
// tb_game_timer_datapath: directed steps with a reference model feeding an
// expectation queue, plus fixed-value checks at the key test-plan points.
module tb_game_timer_datapath;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_ec = 1'b0, i_ci = 1'b0, i_dl = 1'b0;
    logic       o_wait, o_go, w2_wait, w2_go;
    logic [1:0] o_dir, o_not, o_lives, w2_dir, w2_not, w2_lives, w2_score;
    logic [7:0] o_score;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;
    exp_t q[$];

    int         m_cnt, m_lives, m_score, m_score2;
    logic       m_wait, m_ec_q, m_ci_q, m_dl_q;
    logic [7:0] m_lfsr;

    game_timer_datapath #(.TIMEOUT(TO), .CNT_W(26), .LIVES(3), .LIFE_W(2),
                          .SCORE_W(8), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .i_enable_counter(i_ec), .i_change_instruction(i_ci),
        .i_decrease_life(i_dl), .o_wait_counter(o_wait), .o_instr_dir(o_dir),
        .o_instr_not(o_not), .o_lives(o_lives), .o_score(o_score), .o_game_over(o_go)
    );

    game_timer_datapath #(.TIMEOUT(TO), .CNT_W(26), .LIVES(3), .LIFE_W(2),
                          .SCORE_W(2), .LFSR_SEED(8'hA5)) dut2 (
        .clk(clk), .rst(rst), .i_enable_counter(i_ec), .i_change_instruction(i_ci),
        .i_decrease_life(i_dl), .o_wait_counter(w2_wait), .o_instr_dir(w2_dir),
        .o_instr_not(w2_not), .o_lives(w2_lives), .o_score(w2_score), .o_game_over(w2_go)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input int s);
        case (s)
            0: return 32'(o_wait);
            1: return 32'(o_dir);
            2: return 32'(o_not);
            3: return 32'(o_lives);
            4: return 32'(o_score);
            5: return 32'(o_go);
            6: return 32'(w2_score);
            default: return 'x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input int s, input logic [31:0] e);
        q.push_back('{tag, s, e});
    endtask

    task automatic step(input logic r, input logic ec, input logic ci, input logic dl);
        logic ecr, cir, dlr;
        rst = r; i_ec = ec; i_ci = ci; i_dl = dl;
        if (r) begin
            m_cnt = 0; m_wait = 1'b1; m_lfsr = 8'hA5; m_lives = 3; m_score = 0; m_score2 = 0;
            m_ec_q = 1'b0; m_ci_q = 1'b0; m_dl_q = 1'b0;
        end else begin
            ecr = ec && !m_ec_q;
            cir = ci && !m_ci_q;
            dlr = dl && !m_dl_q;
            if (ec) begin
                m_cnt = 0; m_wait = 1'b0;
            end else if (!m_wait) begin
                if (m_cnt == TO - 1) m_wait = 1'b1;
                else m_cnt++;
            end
            if (cir) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            if (dlr && m_lives > 0) m_lives--;
            if (ecr && !dl) begin
                if (m_score < 255) m_score++;
                if (m_score2 < 3) m_score2++;
            end
            m_ec_q = ec; m_ci_q = ci; m_dl_q = dl;
        end
        push("wait", 0, 32'(m_wait));
        push("dir", 1, 32'(m_lfsr[1:0]));
        push("not", 2, (m_lfsr[3:2] == 2'd3) ? 32'd0 : 32'(m_lfsr[3:2]));
        push("lives", 3, 32'(m_lives));
        push("score", 4, 32'(m_score));
        push("game_over", 5, 32'(m_lives == 0));
        push("score2", 6, 32'(m_score2));
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, obs(e.sig), e.exp);
        end
    endtask

    task automatic correct();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wrong();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int sat2[5];
        sat2 = '{1, 2, 3, 3, 3};
        #2;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_wait", 32'(o_wait), 32'd1);
        chk("rst_lives", 32'(o_lives), 32'd3);
        chk("rst_score", 32'(o_score), 32'd0);
        chk("rst_go", 32'(o_go), 32'd0);
        chk("rst_dir", 32'(o_dir), 32'd1);
        chk("rst_not", 32'(o_not), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("ok_wait_clr", 32'(o_wait), 32'd0);
        chk("ok_score1", 32'(o_score), 32'd1);
        chk("ok_dir", 32'(o_dir), 32'd2);
        chk("ok_not", 32'(o_not), 32'd2);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("ok_score_level", 32'(o_score), 32'd1);
        chk("ok_dir_level", 32'(o_dir), 32'd2);
        for (int k = 1; k <= 14; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("timer_k%0d", k), 32'(o_wait), 32'(k >= TO));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wrong();
            chk($sformatf("wrong%0d_lives", i), 32'(o_lives), 32'(2 - i));
            chk($sformatf("wrong%0d_go", i), 32'(o_go), 32'(i == 2));
        end
        wrong();
        chk("wrong4_lives", 32'(o_lives), 32'd0);
        chk("wrong4_score", 32'(o_score), 32'd0);
        chk("wrong4_go", 32'(o_go), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            correct();
            chk($sformatf("sat_score2_%0d", i), 32'(w2_score), 32'(sat2[i]));
            chk($sformatf("sat_score8_%0d", i), 32'(o_score), 32'(i + 1));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        wrong();
        wrong();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_lives_pre", 32'(o_lives), 32'd1);
        chk("mid_wait_pre", 32'(o_wait), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_wait", 32'(o_wait), 32'd1);
        chk("mid_lives", 32'(o_lives), 32'd3);
        chk("mid_dir", 32'(o_dir), 32'd1);
        chk("mid_not", 32'(o_not), 32'd1);
        chk("mid_score", 32'(o_score), 32'd0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_wait_hold", 32'(o_wait), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
